key_sender: RTL and testbench
=============================

// Module: key_sender
// PURPOSE
//  Keypad stimulus transmitter: drives the 3-bit key bus (IN) of the calculator fsm.
//  Accepts key codes over a valid/ready handshake into a small FIFO, then replays each
//  key as a press (code held HOLD cycles) followed by a release (0 held GAP cycles).
//  Replaces hand-timed testbench key pokes; also usable as a synthesizable key source.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of 2, >=2
//  HOLD   1  cycles KEY shows the code per press; >=1
//  GAP    1  cycles KEY shows 0 after each press; >=1
// PORTS
//  CLK        in   1  clock, rising edge
//  RST        in   1  reset, synchronous, active-high
//  KEY_VALID  in   1  producer offers KEY_DATA
//  KEY_DATA   in   3  key code; 1..7 legal, 0 illegal (0 means "no key")
//  KEY_READY  out  1  FIFO can accept this cycle
//  KEY        out  3  key bus to fsm IN; registered
//  BUSY       out  1  FIFO non-empty or sequencer not IDLE
//  ERR        out  1  one-cycle pulse: zero code was offered and accepted
//  S          out  2  sequencer state (debug)
//  SENT       out  8  keys emitted (only with KEY_SENDER_COUNT_EN)
// BEHAVIOUR
//  Reset: KEY=0, KEY_READY=1, BUSY=0, ERR=0, S=IDLE, FIFO empty, SENT=0. Same on RST mid-operation:
//   the key in progress is abandoned, KEY=0 from the next edge, queued keys discarded.
//  Handshake: transfer when KEY_VALID & KEY_READY at a rising edge. KEY_READY = !full (no
//   combinational path from the pop side; a full FIFO refuses even if popping that cycle).
//  Code 0: transfer completes (handshake consumed), not enqueued, ERR=1 on the following cycle.
//  Simultaneous push and pop on a non-full, non-empty FIFO: both occur, occupancy unchanged.
//  Pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
//  States (S encoding): IDLE=0, PRESS=1, RELEASE=2; 3 unused -> IDLE.
//   IDLE: if FIFO non-empty, pop head into key register, go PRESS; else stay, KEY=0.
//   PRESS: KEY=code for exactly HOLD cycles, then RELEASE.
//   RELEASE: KEY=0 for exactly GAP cycles, then IDLE.
//  Latency: key accepted at edge n -> popped at edge n+1 -> KEY=code from edge n+2.
//  Back-to-back keys: period HOLD+GAP+1 cycles (one IDLE cycle with KEY=0 between keys).
//  Dwell counter width: clog2(max(HOLD,GAP)+1); reloaded on every state entry.
//  BUSY = (S!=IDLE) | !empty.
// CONFIGURATION
//  KEY_SENDER_COUNT_EN defined: SENT port present; +1 on each PRESS->RELEASE transition,
//   wraps 255->0, cleared by RST.
//  Not defined: SENT port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package calc_pkg: key-code width (3), KEY_NONE=0, sequencer state encodings
//   (IDLE/PRESS/RELEASE), shared with the calculator fsm.
//  Sub-module key_fifo (DEPTH, width 3): sync FIFO with push/pop/full/empty, RST flushes.
//  key_sender: handshake/zero filter, sequencer FSM, dwell counter, optional SENT counter.
// TESTING
//  1 Reset: RST=1 two cycles -> KEY=0, KEY_READY=1, BUSY=0, ERR=0, S=0.
//  2 Push 2 then 4 (HOLD=GAP=1) into key_sender->fsm -> KEY = 2,0,0,4,0,0; fsm O=6.
//  3 HOLD=8: offer 6 keys back-to-back -> first popped, next 4 fill FIFO,
//    KEY_READY=0 while 6th offered; 6th accepted after next pop; all 6 emitted in order.
//  4 Offer code 0 between 3 and 5 -> ERR pulses once, KEY shows only 3 then 5.
//  5 RST asserted during PRESS with 2 keys queued -> KEY=0 next edge, BUSY=0, no further keys.
//  6 KEY_SENDER_COUNT_EN: emit 257 keys -> SENT=1; without macro build compiles, no SENT port.

Source files
------------

// File: rtl/calc_pkg.sv
// Definitions shared by the keypad transmitter and the calculator fsm:
// key-code width, the "no key" code and the key sequencer state encoding.
package calc_pkg;

    localparam int KEY_W = 3;

    typedef logic [KEY_W-1:0] key_t;

    localparam key_t KEY_NONE = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_sender_if.sv
// Key-code valid/ready handshake between a key producer (master) and
// the key_sender transmitter (slave).
interface key_sender_if;
    import calc_pkg::*;

    logic KEY_VALID;
    key_t KEY_DATA;
    logic KEY_READY;

    modport master (output KEY_VALID, output KEY_DATA, input KEY_READY);
    modport slave  (input KEY_VALID, input KEY_DATA, output KEY_READY);

endinterface

// File: rtl/key_sender_fifo.sv
// key_fifo: synchronous FIFO holding queued key codes; RST flushes it.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module key_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = KEY_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; a flush only rewinds the pointers.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/key_sender.sv
// key_sender: queues key codes from a valid/ready producer and replays each as a
// press (code for HOLD cycles) then release (0 for GAP cycles). KEY_SENDER_COUNT_EN adds SENT.
module key_sender
    import calc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 1,
    parameter int GAP   = 1
) (
    input  logic         CLK,
    input  logic         RST,
    key_sender_if.slave  kif,
    output key_t         KEY,
    output logic         BUSY,
    output logic         ERR,
    output logic [1:0]   S
`ifdef KEY_SENDER_COUNT_EN
    , output logic [7:0] SENT
`endif
);

    localparam int CNT_W = $clog2(max_int(HOLD, GAP) + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] dwell;
    logic             fifo_full;
    logic             fifo_empty;
    logic             xfer;
    logic             push;
    logic             pop;
    key_t             head;
    key_t             code_p0;
    key_t             key_nxt;
    key_t             key_p1;
    logic             err_p1;

    // Handshake and zero-code filter: a zero code completes the transfer but is dropped.
    assign kif.KEY_READY = ~fifo_full;
    assign xfer          = kif.KEY_VALID & ~fifo_full;
    assign push          = xfer & (kif.KEY_DATA != KEY_NONE);

    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   (kif.KEY_DATA),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = PRESS;
            PRESS:   if (dwell == '0) state_nxt = RELEASE;
            RELEASE: if (dwell == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        key_nxt = KEY_NONE;
        case (state)
            IDLE:    pop     = ~fifo_empty;
            PRESS:   key_nxt = code_p0;
            default: key_nxt = KEY_NONE;
        endcase
    end

    // Dwell counter restarts on every state change and counts down to zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dwell <= '0;
        end else if (state_nxt != state) begin
            dwell <= (state_nxt == PRESS) ? HOLD_LD : GAP_LD;
        end else if (dwell != '0) begin
            dwell <= dwell - 1'b1;
        end
    end

    // Stage p0: popped code captured for the duration of the press.
    always_ff @(posedge CLK) begin
        if (pop) code_p0 <= head;
    end

    // Stage p1: registered key bus and error pulse, one cycle behind the sequencer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_p1 <= KEY_NONE;
            err_p1 <= 1'b0;
        end else begin
            key_p1 <= key_nxt;
            err_p1 <= xfer & (kif.KEY_DATA == KEY_NONE);
        end
    end

`ifdef KEY_SENDER_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            SENT <= '0;
        end else if (state == PRESS && state_nxt == RELEASE) begin
            SENT <= SENT + 8'd1;
        end
    end
`endif

    assign KEY  = key_p1;
    assign ERR  = err_p1;
    assign S    = state;
    assign BUSY = (state != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_key_sender.sv
// Bench for key_sender: a fast (HOLD=1,GAP=1) and a slow (HOLD=8,GAP=2) instance, each
// checked every cycle against a timeline model, plus a vector table and directed sequences.
module tb_key_sender;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    bit         vld [2];
    logic [2:0] din = 3'd0;

    always #5 CLK = ~CLK;

    key_sender_if if_f();
    key_sender_if if_s();

    assign if_f.KEY_VALID = vld[0];
    assign if_f.KEY_DATA  = din;
    assign if_s.KEY_VALID = vld[1];
    assign if_s.KEY_DATA  = din;

    logic [2:0] key_f, key_s;
    logic       busy_f, busy_s, err_f, err_s;
    logic [1:0] s_f, s_s;
`ifdef KEY_SENDER_COUNT_EN
    logic [7:0] sent_f, sent_s;
`endif

    key_sender #(.DEPTH(DEPTH), .HOLD(1), .GAP(1)) u_fast (
        .CLK(CLK), .RST(RST), .kif(if_f),
        .KEY(key_f), .BUSY(busy_f), .ERR(err_f), .S(s_f)
`ifdef KEY_SENDER_COUNT_EN
        , .SENT(sent_f)
`endif
    );

    key_sender #(.DEPTH(DEPTH), .HOLD(8), .GAP(2)) u_slow (
        .CLK(CLK), .RST(RST), .kif(if_s),
        .KEY(key_s), .BUSY(busy_s), .ERR(err_s), .S(s_s)
`ifdef KEY_SENDER_COUNT_EN
        , .SENT(sent_s)
`endif
    );

    // Timeline model: a key popped at edge p shows on KEY during edges p+1..p+HOLD;
    // the sequencer is PRESS for HOLD edges, RELEASE for GAP edges, then IDLE.
    int mq [2][DEPTH];
    int mcnt [2];
    int last_pop [2];
    int mcode [2];
    int msent [2];
    int merr [2];
    int edge_n;
    int n_cmp, n_bad;
    int elog [2][300];
    int ecnt [2];
    int prev_key [2];
    int errs [2];

    function automatic int hold_of(int i); return (i == 0) ? 1 : 8; endfunction
    function automatic int gap_of(int i);  return (i == 0) ? 1 : 2; endfunction

    function automatic logic [31:0] o_key(int i);   return (i == 0) ? 32'(key_f)  : 32'(key_s);  endfunction
    function automatic logic [31:0] o_busy(int i);  return (i == 0) ? 32'(busy_f) : 32'(busy_s); endfunction
    function automatic logic [31:0] o_err(int i);   return (i == 0) ? 32'(err_f)  : 32'(err_s);  endfunction
    function automatic logic [31:0] o_s(int i);     return (i == 0) ? 32'(s_f)    : 32'(s_s);    endfunction
    function automatic logic [31:0] o_ready(int i); return (i == 0) ? 32'(if_f.KEY_READY) : 32'(if_s.KEY_READY); endfunction
`ifdef KEY_SENDER_COUNT_EN
    function automatic logic [31:0] o_sent(int i);  return (i == 0) ? 32'(sent_f) : 32'(sent_s); endfunction
`endif

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", nm, edge_n, act, exp);
        end
    endtask

    function automatic bit model_idle(int i);
        return (mcnt[i] == 0) && (edge_n - last_pop[i] >= hold_of(i) + gap_of(i));
    endfunction

    // One clock: decide model events from pre-edge state, take the edge, check both DUTs.
    task automatic step();
        bit acc [2];
        bit popd [2];
        int d, es, ek;
        string nm;
        for (int i = 0; i < 2; i++) begin
            acc[i]  = vld[i] && (mcnt[i] < DEPTH);
            popd[i] = (edge_n - last_pop[i] >= hold_of(i) + gap_of(i) + 1) && (mcnt[i] > 0);
        end
        @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                mcnt[i] = 0; last_pop[i] = -1000; merr[i] = 0; msent[i] = 0;
            end else begin
                merr[i] = (acc[i] && din == 3'd0) ? 1 : 0;
                if (popd[i]) begin
                    mcode[i] = mq[i][0];
                    for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k + 1];
                    mcnt[i]--;
                    last_pop[i] = edge_n;
                end
                if (acc[i] && din != 3'd0) begin
                    mq[i][mcnt[i]] = int'(din);
                    mcnt[i]++;
                end
                if (edge_n - last_pop[i] == hold_of(i)) msent[i] = (msent[i] + 1) % 256;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            nm = (i == 0) ? "fast" : "slow";
            d  = edge_n - last_pop[i];
            es = (d < hold_of(i)) ? 1 : (d < hold_of(i) + gap_of(i)) ? 2 : 0;
            ek = (d >= 1 && d <= hold_of(i)) ? mcode[i] : 0;
            chk({nm, " KEY"},       o_key(i),   ek);
            chk({nm, " S"},         o_s(i),     es);
            chk({nm, " BUSY"},      o_busy(i),  (es != 0 || mcnt[i] > 0) ? 1 : 0);
            chk({nm, " ERR"},       o_err(i),   merr[i]);
            chk({nm, " KEY_READY"}, o_ready(i), (mcnt[i] < DEPTH) ? 1 : 0);
`ifdef KEY_SENDER_COUNT_EN
            chk({nm, " SENT"},      o_sent(i),  msent[i]);
`endif
            if (o_key(i) != 0 && prev_key[i] == 0 && ecnt[i] < 300) begin
                elog[i][ecnt[i]] = int'(o_key(i));
                ecnt[i]++;
            end
            prev_key[i] = int'(o_key(i));
            if (o_err(i) == 1) errs[i]++;
        end
        edge_n++;
    endtask

    // Hold a code on instance i until the model says it was taken; returns stall cycles seen.
    task automatic offer(int i, int code, output int stalls);
        bit done = 0;
        stalls = 0;
        din    = 3'(code);
        vld[i] = 1;
        for (int t = 0; t < 100 && !done; t++) begin
            if (mcnt[i] < DEPTH) done = 1;
            if (o_ready(i) == 0) stalls++;
            step();
        end
        vld[i] = 0;
        din    = 3'd0;
        chk("offer accepted", done, 1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int t = 0; t < 2000 && !ok; t++) begin
            step();
            ok = model_idle(0) && model_idle(1);
        end
        chk("drain finished", ok, 1);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin ecnt[i] = 0; errs[i] = 0; end
    endtask

    typedef struct {
        bit v;
        int d;
        int k;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int st;
        int exp3 [6];

        tbl[0] = '{1, 2, 0}; tbl[1] = '{1, 4, 0}; tbl[2] = '{0, 0, 2}; tbl[3] = '{0, 0, 0};
        tbl[4] = '{0, 0, 0}; tbl[5] = '{0, 0, 4}; tbl[6] = '{0, 0, 0}; tbl[7] = '{0, 0, 0};

        n_cmp = 0; n_bad = 0; edge_n = 0;
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; last_pop[i] = -1000; mcode[i] = 0; msent[i] = 0; merr[i] = 0;
            prev_key[i] = 0; vld[i] = 0;
        end
        clear_logs();

        // Reset held two cycles
        RST = 1;
        step(); step();
        RST = 0;
        chk("reset KEY", key_f, 0);
        chk("reset KEY_READY", if_f.KEY_READY, 1);
        chk("reset BUSY", busy_f, 0);
        chk("reset ERR", err_f, 0);
        chk("reset S", s_f, 0);

        // Keys 2 then 4 on the fast instance: KEY = 0,0,2,0,0,4,0,0
        for (int n = 0; n < 8; n++) begin
            vld[0] = tbl[n].v;
            din    = 3'(tbl[n].d);
            step();
            chk($sformatf("table KEY row %0d", n), key_f, tbl[n].k);
        end
        vld[0] = 0;
        din    = 3'd0;
        drain();

        // Six back-to-back keys on the slow instance: the sixth must stall, order preserved
        clear_logs();
        for (int n = 1; n <= 6; n++) begin
            offer(1, n, st);
            exp3[n - 1] = n;
            if (n == 6) chk("sixth key stalled", (st > 0) ? 1 : 0, 1);
        end
        drain();
        chk("slow emitted count", ecnt[1], 6);
        for (int n = 0; n < 6; n++) chk($sformatf("slow order %0d", n), elog[1][n], exp3[n]);

        // Zero code between 3 and 5 on the fast instance
        clear_logs();
        offer(0, 3, st);
        offer(0, 0, st);
        offer(0, 5, st);
        drain();
        chk("zero code ERR pulses", errs[0], 1);
        chk("zero code emitted count", ecnt[0], 2);
        chk("zero code first key", elog[0][0], 3);
        chk("zero code second key", elog[0][1], 5);

        // Reset during PRESS with two keys queued on the slow instance
        offer(1, 1, st);
        offer(1, 2, st);
        offer(1, 3, st);
        chk("slow in PRESS before reset", s_s, 1);
        RST = 1;
        step();
        RST = 0;
        chk("mid reset KEY", key_s, 0);
        chk("mid reset BUSY", busy_s, 0);
        clear_logs();
        for (int t = 0; t < 30; t++) step();
        chk("no keys after reset", ecnt[1], 0);

        // Randomized traffic on both instances, occasional reset
        for (int t = 0; t < 900; t++) begin
            vld[0] = ($urandom_range(0, 1) == 1);
            vld[1] = ($urandom_range(0, 2) == 0);
            din    = 3'($urandom_range(0, 7));
            RST    = ($urandom_range(0, 199) == 0);
            step();
        end
        RST = 0; vld[0] = 0; vld[1] = 0; din = 3'd0;
        drain();

`ifdef KEY_SENDER_COUNT_EN
        RST = 1;
        step();
        RST = 0;
        for (int n = 0; n < 257; n++) offer(0, (n % 7) + 1, st);
        drain();
        chk("SENT after 257 keys", sent_f, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
